// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with two-flop synchronizer, mid-bit sampling,
// framing-error detection and break handling.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_output,
    output logic       uart_rx_valid,
    output logic       uart_rx_error,
    output logic       uart_rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state;
    logic          s1;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            s1             <= 1'b1;
            rx_s           <= 1'b1;
            cnt            <= '0;
            idx            <= '0;
            shift          <= '0;
            uart_rx_output <= '0;
            uart_rx_valid  <= 1'b0;
            uart_rx_error  <= 1'b0;
            uart_rx_busy   <= 1'b0;
        end else begin
            s1            <= uart_rxd;
            rx_s          <= s1;
            uart_rx_valid <= 1'b0;
            uart_rx_error <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state        <= START;
                    cnt          <= '0;
                    uart_rx_busy <= 1'b1;
                end
                START: if (cnt == HALF_M1) begin
                    // a start bit that is high again at its centre was only a glitch
                    if (rx_s) begin
                        state        <= IDLE;
                        uart_rx_busy <= 1'b0;
                    end else begin
                        state <= DATA;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == FULL_M1) begin
                    shift[idx] <= rx_s;
                    cnt        <= '0;
                    idx        <= idx + 3'd1;
                    if (idx == 3'd7) state <= STOP;
                end else cnt <= cnt + 1'b1;
                STOP: if (cnt == FULL_M1) begin
                    if (rx_s) begin
                        state          <= IDLE;
                        uart_rx_output <= shift;
                        uart_rx_valid  <= 1'b1;
                        uart_rx_busy   <= 1'b0;
                    end else begin
                        state         <= WAIT_IDLE;
                        uart_rx_error <= 1'b1;
                    end
                end else cnt <= cnt + 1'b1;
                WAIT_IDLE: if (rx_s) begin
                    state        <= IDLE;
                    uart_rx_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level model of
// the receiver (expected bytes, pulse cycles and error counts).
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // posedges from the driving negedge to the edge after which the pulse is visible
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_rx_output;
    logic       uart_rx_valid;
    logic       uart_rx_error;
    logic       uart_rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int both_cnt = 0;
    logic [7:0] vq[$];
    int vc[$];
    int ec[$];
    bit busy_seen = 0;
    int busy_first = 0;
    int busy_last = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .uart_rxd(uart_rxd),
        .uart_rx_output(uart_rx_output),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_error(uart_rx_error),
        .uart_rx_busy(uart_rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_rx_valid) begin
            vq.push_back(uart_rx_output);
            vc.push_back(cyc);
        end
        if (uart_rx_error) ec.push_back(cyc);
        if (uart_rx_valid && uart_rx_error) both_cnt <= both_cnt + 1;
        if (uart_rx_busy) begin
            if (!busy_seen) begin
                busy_first = cyc;
                busy_seen = 1;
            end
            busy_last = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        vq.delete();
        vc.delete();
        ec.delete();
        busy_seen = 0;
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, output int t);
        t = cyc;
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(4);
        clear_mon();
    endtask

    initial begin
        int t0, t1;
        logic [7:0] exp_b[$];
        int exp_c[$];
        int exp_e[$];
        repeat (2) @(negedge clk);
        chk("rst_output", uart_rx_output, 8'h00);
        chk("rst_valid", uart_rx_valid, 1'b0);
        chk("rst_error", uart_rx_error, 1'b0);
        chk("rst_busy", uart_rx_busy, 1'b0);
        reset = 1'b0;
        idle(4);
        clear_mon();

        send(8'h34, 1'b1, t0);
        idle(CPB);
        chk("x34_count", vq.size(), 1);
        if (vq.size() == 1) begin
            chk("x34_data", vq[0], 8'h34);
            chk("x34_cycle", vc[0], t0 + LAT);
        end
        chk("x34_errs", ec.size(), 0);
        chk("x34_output", uart_rx_output, 8'h34);
        chk("x34_busy_rise", busy_first, t0 + 3);
        chk("x34_busy_fall", busy_last, t0 + LAT - 1);
        clear_mon();

        send(8'h55, 1'b1, t0);
        send(8'hAA, 1'b1, t1);
        idle(CPB);
        chk("b2b_count", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("b2b_d0", vq[0], 8'h55);
            chk("b2b_d1", vq[1], 8'hAA);
            chk("b2b_gap", vc[1] - vc[0], 10 * CPB);
        end
        chk("b2b_errs", ec.size(), 0);
        clear_mon();

        t0 = cyc;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * CPB);
        chk("glitch_valid", vq.size(), 0);
        chk("glitch_errs", ec.size(), 0);
        chk("glitch_busy_rise", busy_first, t0 + 3);
        chk("glitch_busy_fall", busy_last, t0 + 3 + HALF - 1);
        chk("glitch_busy_now", uart_rx_busy, 1'b0);

        do_reset();
        send(8'h00, 1'b0, t0);
        repeat (10 * CPB) @(negedge clk);
        idle(2 * CPB);
        chk("break_errs", ec.size(), 1);
        if (ec.size() == 1) chk("break_err_cycle", ec[0], t0 + LAT);
        chk("break_valid", vq.size(), 0);
        chk("break_output", uart_rx_output, 8'h00);
        chk("break_busy", uart_rx_busy, 1'b0);
        clear_mon();
        send(8'h3C, 1'b1, t0);
        idle(CPB);
        chk("after_break_count", vq.size(), 1);
        if (vq.size() == 1) chk("after_break_data", vq[0], 8'h3C);
        chk("after_break_output", uart_rx_output, 8'h3C);
        clear_mon();

        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("mid_busy_before", uart_rx_busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_output", uart_rx_output, 8'h00);
        chk("mid_rst_busy", uart_rx_busy, 1'b0);
        chk("mid_rst_valid", uart_rx_valid, 1'b0);
        chk("mid_rst_error", uart_rx_error, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(5 * CPB);
        chk("mid_no_valid", vq.size(), 0);
        chk("mid_no_error", ec.size(), 0);
        send(8'h0F, 1'b1, t0);
        idle(CPB);
        chk("after_rst_count", vq.size(), 1);
        if (vq.size() == 1) chk("after_rst_data", vq[0], 8'h0F);
        clear_mon();

        send(8'h34, 1'b1, t0);
        exp_b.push_back(8'h34);
        exp_c.push_back(t0 + LAT);
        send(8'h55, 1'b1, t0);
        exp_b.push_back(8'h55);
        exp_c.push_back(t0 + LAT);
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic good;
            b = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send(b, good, t0);
            if (good) begin
                exp_b.push_back(b);
                exp_c.push_back(t0 + LAT);
                idle($urandom_range(0, 20));
            end else begin
                exp_e.push_back(t0 + LAT);
                idle(CPB + $urandom_range(0, 20));
            end
        end
        idle(CPB);
        chk("rand_count", vq.size(), exp_b.size());
        chk("rand_errs", ec.size(), exp_e.size());
        for (int i = 0; i < vq.size() && i < exp_b.size(); i++) begin
            chk($sformatf("rand_data%0d", i), vq[i], exp_b[i]);
            chk($sformatf("rand_cycle%0d", i), vc[i], exp_c[i]);
        end
        for (int i = 0; i < ec.size() && i < exp_e.size(); i++)
            chk($sformatf("rand_err_cycle%0d", i), ec[i], exp_e[i]);
        chk("valid_error_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
